store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/sb_pkg.sv | 14 +
 rtl/sb_fwd_match.sv | 37 +++
 rtl/store_buffer.sv | 110 +++++++++++
 tb/tb_store_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Store buffer shared definitions: default geometry and the buffered-entry record.
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  // One buffered store: word address plus the data to be written there.
  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding match: finds the youngest valid entry whose address
// equals the load address and returns its data.
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic [AW-1:0]              ent_addr [DEPTH],
  input  logic [DW-1:0]              ent_data [DEPTH],
  input  logic [DEPTH-1:0]           ent_vld,
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [AW-1:0]              ld_addr,
  output logic                       hit,
  output logic [DW-1:0]              data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk from oldest (head) to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (ent_vld[idx] && (ent_addr[idx] == ld_addr)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores between the MEM stage and the
// data memory. Drains one store per cycle when the memory port is free and
// forwards buffered data to loads that hit a pending address.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                     CLK,
  input  logic                     SB_reset,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [DW-1:0]            ld_data,
  input  logic                     DM_busy,
  output logic                     DM_WE,
  output logic [AW-1:0]            DM_A,
  output logic [DW-1:0]            DM_WD,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PW-1:0]    off;
  logic             do_enq;
  logic             do_deq;
  logic             fwd_hit;
  logic [DW-1:0]    fwd_data;

  // Handshake and drain decisions; st_ready depends only on registered count.
  always_comb begin
    empty    = (count == '0);
    st_ready = (count != FULL);
    do_enq   = st_valid && st_ready;
    DM_WE    = !empty && !DM_busy;
    do_deq   = DM_WE;
    DM_A     = empty ? '0 : ent_addr[head];
    DM_WD    = empty ? '0 : ent_data[head];
  end

  // Pointer and occupancy state; reset discards everything that is buffered.
  always_ff @(posedge CLK or negedge SB_reset) begin
    if (!SB_reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq) tail <= tail + PW'(1);
      if (do_deq) head <= head + PW'(1);
      case ({do_enq, do_deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: the valid mask keeps stale slots off the outputs.
  always_ff @(posedge CLK) begin
    if (do_enq) begin
      ent_addr[tail] <= st_addr;
      ent_data[tail] <= st_data;
    end
  end

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    ent_vld = '0;
    off     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      off        = PW'(k) - head;
      ent_vld[k] = ({1'b0, off} < count);
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .ent_addr (ent_addr),
    .ent_data (ent_data),
    .ent_vld  (ent_vld),
    .head     (head),
    .ld_addr  (ld_addr),
    .hit      (fwd_hit),
    .data     (fwd_data)
  );

  // Forwarding is only reported for an active load; data is zero on a miss.
  always_comb begin
    ld_hit  = ld_valid && fwd_hit;
    ld_data = ld_hit ? fwd_data : '0;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, hand-written corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_store_buffer;
  import sb_pkg::*;

  logic        CLK = 1'b0;
  logic        SB_reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        DM_busy;
  logic        DM_WE;
  logic [31:0] DM_A;
  logic [31:0] DM_WD;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;

  sb_entry_t q[$];

  always #5 CLK = ~CLK;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .CLK      (CLK),
    .SB_reset (SB_reset),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .DM_busy  (DM_busy),
    .DM_WE    (DM_WE),
    .DM_A     (DM_A),
    .DM_WD    (DM_WD),
    .count    (count),
    .empty    (empty)
  );

  typedef struct {
    logic        sv;
    logic [31:0] sa;
    logic [31:0] sd;
    logic        lv;
    logic [31:0] la;
    logic        busy;
    int          e_cnt;
    logic        e_rdy;
    logic        e_we;
    logic [31:0] e_a;
    logic [31:0] e_wd;
    logic        e_hit;
    logic [31:0] e_ld;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la, input logic busy);
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la; DM_busy = busy;
  endtask

  // One clock of traffic checked against the queue model, then the model steps.
  task automatic run_cycle(input string tag, input logic sv, input logic [31:0] sa,
                           input logic [31:0] sd, input logic lv, input logic [31:0] la,
                           input logic busy);
    int          n;
    logic        e_rdy, e_we, e_hit;
    logic [31:0] e_a, e_wd, e_ld;
    @(negedge CLK);
    drive(sv, sa, sd, lv, la, busy);
    #1;
    n     = q.size();
    e_rdy = (n != 4);
    e_we  = (n != 0) && !busy;
    e_a   = (n != 0) ? q[0].addr : 32'h0;
    e_wd  = (n != 0) ? q[0].data : 32'h0;
    e_hit = 1'b0;
    e_ld  = 32'h0;
    if (lv) begin
      for (int i = 0; i < n; i++) begin
        if (q[i].addr == la) begin
          e_hit = 1'b1;
          e_ld  = q[i].data;
        end
      end
    end
    chk({tag, " count"},    64'(count),    64'(n));
    chk({tag, " empty"},    64'(empty),    64'(n == 0));
    chk({tag, " st_ready"}, 64'(st_ready), 64'(e_rdy));
    chk({tag, " DM_WE"},    64'(DM_WE),    64'(e_we));
    chk({tag, " DM_A"},     64'(DM_A),     64'(e_a));
    chk({tag, " DM_WD"},    64'(DM_WD),    64'(e_wd));
    chk({tag, " ld_hit"},   64'(ld_hit),   64'(e_hit));
    chk({tag, " ld_data"},  64'(ld_data),  64'(e_ld));
    @(posedge CLK);
    if (e_we) void'(q.pop_front());
    if (sv && e_rdy) q.push_back('{addr: sa, data: sd});
  endtask

  // Assert reset away from any clock edge and confirm outputs clear at once.
  task automatic do_reset(input logic [31:0] la);
    @(negedge CLK);
    #2;
    drive(1'b0, 32'h0, 32'h0, 1'b1, la, 1'b0);
    SB_reset = 1'b0;
    #1;
    chk("rst count",    64'(count),    64'd0);
    chk("rst empty",    64'(empty),    64'd1);
    chk("rst st_ready", 64'(st_ready), 64'd1);
    chk("rst DM_WE",    64'(DM_WE),    64'd0);
    chk("rst DM_A",     64'(DM_A),     64'd0);
    chk("rst DM_WD",    64'(DM_WD),    64'd0);
    chk("rst ld_hit",   64'(ld_hit),   64'd0);
    chk("rst ld_data",  64'(ld_data),  64'd0);
    @(posedge CLK);
    @(negedge CLK);
    SB_reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    q.delete();
  endtask

  initial begin
    SB_reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    //          sv    sa     sd       lv    la     busy cnt rdy  we    a      wd       hit   ld
    tbl[0] = '{1'b1, 32'h10, 32'hAAAA, 1'b0, 32'h0,  1'b0, 0, 1'b1, 1'b0, 32'h0,  32'h0,    1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h0,  32'h0,    1'b0, 32'h0,  1'b0, 1, 1'b1, 1'b1, 32'h10, 32'hAAAA, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 32'h0,  32'h0,    1'b0, 32'h0,  1'b0, 0, 1'b1, 1'b0, 32'h0,  32'h0,    1'b0, 32'h0};
    tbl[3] = '{1'b1, 32'h20, 32'h1,    1'b0, 32'h0,  1'b1, 0, 1'b1, 1'b0, 32'h0,  32'h0,    1'b0, 32'h0};
    tbl[4] = '{1'b1, 32'h20, 32'h2,    1'b1, 32'h20, 1'b1, 1, 1'b1, 1'b0, 32'h20, 32'h1,    1'b1, 32'h1};
    tbl[5] = '{1'b0, 32'h0,  32'h0,    1'b1, 32'h20, 1'b1, 2, 1'b1, 1'b0, 32'h20, 32'h1,    1'b1, 32'h2};
    tbl[6] = '{1'b0, 32'h0,  32'h0,    1'b1, 32'h24, 1'b1, 2, 1'b1, 1'b0, 32'h20, 32'h1,    1'b0, 32'h0};
    tbl[7] = '{1'b0, 32'h0,  32'h0,    1'b1, 32'h20, 1'b0, 2, 1'b1, 1'b1, 32'h20, 32'h1,    1'b1, 32'h2};
    tbl[8] = '{1'b0, 32'h0,  32'h0,    1'b1, 32'h20, 1'b0, 1, 1'b1, 1'b1, 32'h20, 32'h2,    1'b1, 32'h2};
    tbl[9] = '{1'b0, 32'h0,  32'h0,    1'b1, 32'h20, 1'b0, 0, 1'b1, 1'b0, 32'h0,  32'h0,    1'b0, 32'h0};

    repeat (2) @(posedge CLK);
    do_reset(32'h0);

    // Directed table: single store latency, then forwarding of repeated stores.
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      drive(tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].lv, tbl[i].la, tbl[i].busy);
      #1;
      chk($sformatf("vec%0d count", i),    64'(count),    64'(tbl[i].e_cnt));
      chk($sformatf("vec%0d st_ready", i), 64'(st_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("vec%0d DM_WE", i),    64'(DM_WE),    64'(tbl[i].e_we));
      chk($sformatf("vec%0d DM_A", i),     64'(DM_A),     64'(tbl[i].e_a));
      chk($sformatf("vec%0d DM_WD", i),    64'(DM_WD),    64'(tbl[i].e_wd));
      chk($sformatf("vec%0d ld_hit", i),   64'(ld_hit),   64'(tbl[i].e_hit));
      chk($sformatf("vec%0d ld_data", i),  64'(ld_data),  64'(tbl[i].e_ld));
      @(posedge CLK);
    end

    // Fill while memory is busy: fifth store refused, then ordered drain.
    do_reset(32'h0);
    for (int i = 0; i < 5; i++)
      run_cycle("fill", 1'b1, 32'h100 + 32'(4 * i), 32'(i + 1), 1'b0, 32'h0, 1'b1);
    @(negedge CLK);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("full count",    64'(count),    64'd4);
    chk("full st_ready", 64'(st_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      drive(i == 0, 32'h500, 32'h55, 1'b0, 32'h0, 1'b0);
      #1;
      chk("drain DM_WE", 64'(DM_WE), 64'd1);
      chk("drain DM_A",  64'(DM_A),  64'h100 + 64'(4 * i));
      chk("drain DM_WD", 64'(DM_WD), 64'(i + 1));
      @(posedge CLK);
      void'(q.pop_front());
    end
    run_cycle("drained", 1'b0, 32'h0, 32'h0, 1'b1, 32'h500, 1'b0);

    // Enqueue and drain on the same edge keep count at two; then pointer wrap.
    do_reset(32'h0);
    run_cycle("pre2", 1'b1, 32'h40, 32'h40, 1'b0, 32'h0, 1'b1);
    run_cycle("pre2", 1'b1, 32'h44, 32'h44, 1'b0, 32'h0, 1'b1);
    run_cycle("both", 1'b1, 32'h48, 32'h48, 1'b0, 32'h0, 1'b0);
    @(negedge CLK);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("both count", 64'(count), 64'd2);
    chk("both DM_A",  64'(DM_A),  64'h44);
    for (int i = 0; i < 10; i++)
      run_cycle("wrap", 1'b1, 32'h200 + 32'(4 * i), 32'h9000 + 32'(i), 1'b1,
                32'h200 + 32'(4 * (i - 1)), 1'(i % 3 == 0));
    for (int i = 0; i < 6; i++)
      run_cycle("wrapd", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Reset with three stores pending: nothing may reach memory afterwards.
    for (int i = 0; i < 3; i++)
      run_cycle("pre3", 1'b1, 32'h300 + 32'(4 * i), 32'h30 + 32'(i), 1'b0, 32'h0, 1'b1);
    do_reset(32'h304);
    for (int i = 0; i < 3; i++)
      run_cycle("postrst", 1'b0, 32'h0, 32'h0, 1'b1, 32'h304, 1'b0);

    // Randomized traffic over a small address set to provoke frequent matches.
    for (int i = 0; i < 400; i++)
      run_cycle("rand", 1'($urandom_range(0, 2) != 0), 32'($urandom_range(0, 7) * 4),
                $urandom, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7) * 4),
                1'($urandom_range(0, 9) < 4));
    for (int i = 0; i < 6; i++)
      run_cycle("flush", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
